// File: rtl/cs_key_sched_ctrl_if.sv
// rtl/cs_key_sched_ctrl_if.sv - control, fci datapath, subkey stream and read-port bundle
interface cs_key_sched_ctrl_if;
  logic          i_start;
  logic [127:0]  i_key;
  logic          i_flush;
  logic          o_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_keys_valid;
  logic [63:0]   o_fci_ci;
  logic [63:0]   o_fci_iword;
  logic [63:0]   i_fci_oword;
  logic          o_sk_valid;
  logic [3:0]    o_sk_idx;
  logic [63:0]   o_sk_data;
  logic [3:0]    i_rd_idx;
  logic [63:0]   o_rd_key;

  modport master (
    output i_start, i_key, i_flush, i_fci_oword, i_rd_idx,
    input  o_ready, o_busy, o_done, o_keys_valid, o_fci_ci, o_fci_iword,
           o_sk_valid, o_sk_idx, o_sk_data, o_rd_key
  );

  modport slave (
    input  i_start, i_key, i_flush, i_fci_oword, i_rd_idx,
    output o_ready, o_busy, o_done, o_keys_valid, o_fci_ci, o_fci_iword,
           o_sk_valid, o_sk_idx, o_sk_data, o_rd_key
  );
endinterface

// File: rtl/cs_key_sched_ctrl.sv
// rtl/cs_key_sched_ctrl.sv - CS-Cipher key expansion sequencer driving an external fci datapath
module cs_key_sched_ctrl #(
  parameter int NSUB = 9,
  parameter logic [NSUB-1:0][63:0] C_KS = {
    64'h03c54b5a46a34465, 64'ha40e7ef6204a6230, 64'h3f967f6ebf149dac,
    64'hb700f76f73841163, 64'h3c18e6e7faadb889, 64'h21b6694ea5728708,
    64'h972ed7d635ae1716, 64'h1f855f585b013986, 64'h290d61409ceb9e8f
  }
) (
  input logic                i_clk,
  input logic                i_rst,
  cs_key_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(NSUB - 1);

  state_t       r_state;
  logic [3:0]   r_i;
  logic [63:0]  r_kprev1;
  logic [63:0]  r_kprev2;
  logic [63:0]  r_bank [NSUB];
  logic [63:0]  r_rd_key;
  logic         r_ready;
  logic         r_busy;
  logic         r_done;
  logic         r_keys_valid;

  logic         w_run;
  logic [63:0]  w_sk_data;

  assign w_run     = (r_state == S_RUN);
  assign w_sk_data = r_kprev2 ^ bus.i_fci_oword;

  assign bus.o_fci_ci     = w_run ? C_KS[r_i] : 64'd0;
  assign bus.o_fci_iword  = w_run ? r_kprev1 : 64'd0;
  assign bus.o_sk_valid   = w_run;
  assign bus.o_sk_idx     = w_run ? r_i : 4'd0;
  assign bus.o_sk_data    = w_run ? w_sk_data : 64'd0;
  assign bus.o_ready      = r_ready;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_keys_valid = r_keys_valid;
  assign bus.o_rd_key     = r_rd_key;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_i          <= 4'd0;
      r_kprev1     <= 64'd0;
      r_kprev2     <= 64'd0;
      r_rd_key     <= 64'd0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
      for (int k = 0; k < NSUB; k++) r_bank[k] <= 64'd0;
    end else begin
      // Non-blocking read: an index written on this edge still returns its old contents
      r_rd_key <= (bus.i_rd_idx <= LAST) ? r_bank[bus.i_rd_idx] : 64'd0;
      if (bus.i_flush) begin
        r_state      <= S_IDLE;
        r_i          <= 4'd0;
        r_ready      <= 1'b1;
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
        r_keys_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (bus.i_start) begin
              r_kprev1     <= bus.i_key[127:64];
              r_kprev2     <= bus.i_key[63:0];
              r_i          <= 4'd0;
              r_keys_valid <= 1'b0;
              r_ready      <= 1'b0;
              r_busy       <= 1'b1;
              r_state      <= S_RUN;
            end
          end
          S_RUN: begin
            r_bank[r_i] <= w_sk_data;
            r_kprev2    <= r_kprev1;
            r_kprev1    <= w_sk_data;
            if (r_i == LAST) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_keys_valid <= 1'b1;
              r_ready      <= 1'b1;
              r_busy       <= 1'b0;
            end else begin
              r_i <= r_i + 4'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
